// File: rtl/pipe_scheduler.sv
// Pipe scheduler for a side-scrolling game: seeds two pipes from the LFSR,
// scrolls them on each frame tick, respawns them off the left edge and counts passes.
module pipe_scheduler #(
  parameter int SPAWN_X = 640,
  parameter int SPACING = 320,
  parameter int SPEED   = 2,
  parameter int GAP_MIN = 100,
  parameter int BIRD_X  = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic       crash,
  input  logic [8:0] rnd_in,
  output logic       lfsr_init,
  output logic [9:0] pipe0_x,
  output logic [9:0] pipe1_x,
  output logic [8:0] pipe0_y,
  output logic [8:0] pipe1_y,
  output logic       running,
  output logic [7:0] score,
  output logic       score_pulse
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_LOAD0 = 3'd2;
  localparam logic [2:0] S_LOAD1 = 3'd3;
  localparam logic [2:0] RUN     = 3'd4;
  localparam logic [2:0] FROZEN  = 3'd5;

  localparam logic [9:0] SPAWN0_C = 10'(SPAWN_X);
  localparam logic [9:0] SPAWN1_C = 10'(SPAWN_X + SPACING);
  localparam logic [9:0] SPEED_C  = 10'(SPEED);
  localparam logic [9:0] BIRD_C   = 10'(BIRD_X);
  localparam logic [8:0] GAP_C    = 9'(GAP_MIN);

  // Only the low byte of the LFSR is used so the gap centre never exceeds 9 bits.
  function automatic logic [8:0] gap_map(input logic [8:0] r);
    return GAP_C + {1'b0, r[7:0]};
  endfunction

  logic [2:0] state_r, state_nxt_s;
  logic [9:0] pipe0_x_r, pipe1_x_r;
  logic [8:0] pipe0_y_r, pipe1_y_r;
  logic [7:0] score_r;
  logic       score_pulse_r, lfsr_init_r, running_r;

  logic [9:0] step0_s, step1_s;
  logic       respawn0_s, respawn1_s, pass0_s, pass1_s, adv_s;
  logic [1:0] pass_cnt_s;
  logic [8:0] score_sum_s;
  logic [7:0] score_sat_s;

  // Game-flow next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt_s = S_INIT;  else state_nxt_s = IDLE;
      S_INIT:  state_nxt_s = S_LOAD0;
      S_LOAD0: state_nxt_s = S_LOAD1;
      S_LOAD1: state_nxt_s = RUN;
      RUN:     if (crash) state_nxt_s = FROZEN;  else state_nxt_s = RUN;
      FROZEN:  if (start) state_nxt_s = S_INIT;  else state_nxt_s = FROZEN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Per-tick scroll, respawn and pass detection; a respawning pipe counts as
  // having crossed the bird column if it started at or right of it.
  always_comb begin
    adv_s       = (state_r == RUN) && tick && !crash;
    step0_s     = pipe0_x_r - SPEED_C;
    step1_s     = pipe1_x_r - SPEED_C;
    respawn0_s  = (pipe0_x_r < SPEED_C);
    respawn1_s  = (pipe1_x_r < SPEED_C);
    pass0_s     = (pipe0_x_r >= BIRD_C) && (respawn0_s || (step0_s < BIRD_C));
    pass1_s     = (pipe1_x_r >= BIRD_C) && (respawn1_s || (step1_s < BIRD_C));
    pass_cnt_s  = {1'b0, pass0_s} + {1'b0, pass1_s};
    score_sum_s = {1'b0, score_r} + {7'd0, pass_cnt_s};
    if (score_sum_s[8]) begin
      score_sat_s = 8'hFF;
    end else begin
      score_sat_s = score_sum_s[7:0];
    end
  end

  // State register with the status outputs registered against the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      lfsr_init_r <= 1'b0;
      running_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      lfsr_init_r <= (state_nxt_s == S_INIT);
      running_r   <= (state_nxt_s == RUN);
    end
  end

  // Pipe position and gap registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe0_x_r <= 10'd0;
      pipe1_x_r <= 10'd0;
      pipe0_y_r <= 9'd0;
      pipe1_y_r <= 9'd0;
    end else begin
      case (state_r)
        S_LOAD0: begin
          pipe0_x_r <= SPAWN0_C;
          pipe0_y_r <= gap_map(rnd_in);
        end
        S_LOAD1: begin
          pipe1_x_r <= SPAWN1_C;
          pipe1_y_r <= gap_map(rnd_in);
        end
        RUN: begin
          if (adv_s) begin
            pipe0_x_r <= respawn0_s ? SPAWN0_C : step0_s;
            pipe0_y_r <= respawn0_s ? gap_map(rnd_in) : pipe0_y_r;
            pipe1_x_r <= respawn1_s ? SPAWN0_C : step1_s;
            pipe1_y_r <= respawn1_s ? gap_map(rnd_in) : pipe1_y_r;
          end else begin
            pipe0_x_r <= pipe0_x_r;
            pipe1_x_r <= pipe1_x_r;
            pipe0_y_r <= pipe0_y_r;
            pipe1_y_r <= pipe1_y_r;
          end
        end
        default: begin
          pipe0_x_r <= pipe0_x_r;
          pipe1_x_r <= pipe1_x_r;
          pipe0_y_r <= pipe0_y_r;
          pipe1_y_r <= pipe1_y_r;
        end
      endcase
    end
  end

  // Saturating score and its one-cycle pass pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_r       <= 8'd0;
      score_pulse_r <= 1'b0;
    end else if (state_r == S_INIT) begin
      score_r       <= 8'd0;
      score_pulse_r <= 1'b0;
    end else if (adv_s) begin
      score_r       <= score_sat_s;
      score_pulse_r <= (pass_cnt_s != 2'd0);
    end else begin
      score_r       <= score_r;
      score_pulse_r <= 1'b0;
    end
  end

  assign lfsr_init   = lfsr_init_r;
  assign running     = running_r;
  assign pipe0_x     = pipe0_x_r;
  assign pipe1_x     = pipe1_x_r;
  assign pipe0_y     = pipe0_y_r;
  assign pipe1_y     = pipe1_y_r;
  assign score       = score_r;
  assign score_pulse = score_pulse_r;

endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 Parameter SPAWN_X, default 640: x loaded into a pipe on spawn/respawn.
REQ-002 Parameter SPACING, default 320: initial x offset of pipe1 relative to pipe0.
REQ-003 Parameter SPEED, default 2: pixels each pipe moves left per tick.
REQ-004 Parameter GAP_MIN, default 100: lowest gap-centre y.
REQ-005 Parameter BIRD_X, default 160: x column used for scoring.
REQ-006 clk  input  1  single system clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  level; begin or restart a game.
REQ-009 tick  input  1  one-cycle frame/scroll strobe.
REQ-010 crash  input  1  level; bird collision, freezes the game.
REQ-011 rnd_in  input  9  current LFSR value (Random P_y), changes every cycle.
REQ-012 lfsr_init  output  1  one-cycle pulse to the LFSR init input.
REQ-013 pipe0_x, pipe1_x  output  10 each  pipe left-edge x.
REQ-014 pipe0_y, pipe1_y  output  9 each  pipe gap-centre y.
REQ-015 running  output  1  high only in RUN.
REQ-016 score  output  8  pipes passed; score_pulse output 1, one cycle per pass.

Function
REQ-017 FSM states SHALL be IDLE, S_INIT, S_LOAD0, S_LOAD1, RUN, FROZEN.
REQ-018 IDLE: start=1 -> S_INIT; otherwise stay.
REQ-019 S_INIT: lfsr_init=1 for exactly this cycle, score cleared to 0 -> S_LOAD0 unconditionally.
REQ-020 S_LOAD0: pipe0_x<=SPAWN_X, pipe0_y<=map(rnd_in) -> S_LOAD1.
REQ-021 S_LOAD1: pipe1_x<=SPAWN_X+SPACING, pipe1_y<=map(rnd_in) -> RUN.
REQ-022 map(r) SHALL be GAP_MIN + r[7:0], 9-bit result, range 100..355, no overflow.
REQ-023 RUN, tick=1, crash=0: each pipe with x>=SPEED SHALL get x<=x-SPEED; a pipe with x<SPEED SHALL respawn: x<=SPAWN_X, y<=map(rnd_in) of that cycle.
REQ-024 Both pipes respawning on the same tick SHALL both take the same map(rnd_in).
REQ-025 RUN, tick=1, crash=0: a pipe with x>=BIRD_X and x-SPEED<BIRD_X SHALL assert score_pulse next cycle and increment score; two such pipes in one tick increment score by 2 with one pulse.
REQ-026 score SHALL saturate at 255 (no wrap); score_pulse still fires.
REQ-027 RUN, crash=1 -> FROZEN; crash has priority over simultaneous tick (no movement, no score).
REQ-028 FROZEN: pipe positions and score held; start=1 -> S_INIT (restart); tick ignored.
REQ-029 start while in RUN or in S_INIT/S_LOAD0/S_LOAD1 SHALL be ignored; tick ignored outside RUN.
REQ-030 lfsr_init SHALL be low in every state except S_INIT.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, pipe0_x=pipe1_x=0, pipe0_y=pipe1_y=0, score=0, score_pulse=0, lfsr_init=0, running=0, regardless of clk.
REQ-032 Reset asserted mid-game or mid-seed SHALL abort without further lfsr_init pulse; release returns to IDLE awaiting start.

Verification
REQ-033 Reset release, start pulse, LFSR connected -> lfsr_init high 1 cycle; pipe0=(640,355), pipe1=(960,243); running=1 after S_LOAD1.
REQ-034 RUN, 10 ticks -> pipe0_x=620, pipe1_x=940, score unchanged at 0.
REQ-035 Preload pipe0_x=161 in RUN, one tick -> pipe0_x=159, score_pulse 1 cycle, score=1.
REQ-036 pipe0_x=1, one tick with rnd_in=0x0FF -> pipe0_x=640, pipe0_y=355.
REQ-037 crash and tick same cycle -> FROZEN, x unchanged, score unchanged; later start -> S_INIT, score=0.
REQ-038 score=255, pass event -> score stays 255, score_pulse asserted; rst=0 mid-RUN between clock edges -> outputs zero immediately.
